ext_line_memory: RTL and testbench



---
 rtl/mem_pkg.sv | 20 ++
 rtl/ext_line_memory.sv | 112 +++++++++++
 tb/tb_ext_line_memory.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the external line memory and the L1 data cache
// controller that talks to it.
//   LINE_W   : cache line width in bits
//   OFFSET_W : byte-offset bits inside a line (ignored by the memory)
//   state_e  : request-handshake state encoding
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage : mem_pkg

// File: rtl/ext_line_memory.sv
// -----------------------------------------------------------------------------
// ext_line_memory
// Off-chip data memory model serving L1 line fills and write-backs. One request
// is outstanding at a time; each completes LATENCY rising edges after it is
// accepted, signalled by a single-cycle ack pulse.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset (storage array is preserved)
//   cs      in   request strobe, sampled only in IDLE
//   we      in   1 = write line, 0 = read line
//   addr    in   byte address; line index = addr[ADDR_W+4:5], other bits alias
//   data_i  in   write line data
//   data_o  out  read line data, held until the next read completes
//   ack     out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module ext_line_memory
    import mem_pkg::*;
#(
    parameter int LATENCY = 10,              // legal range 1..255
    parameter int ADDR_W  = 10,
    parameter int LINE_W  = mem_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e              state_q;
    logic [7:0]          cnt_q;
    logic                req_we_q;
    logic [ADDR_W-1:0]   req_idx_q;
    logic [LINE_W-1:0]   req_data_q;
    logic [LINE_W-1:0]   mem_q [DEPTH];

    logic [ADDR_W-1:0]   addr_idx;
    logic                access_fire;

    // Byte-offset and upper address bits are don't-care: upper bits alias.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_W+OFFSET_W], addr[OFFSET_W-1:0]};

    assign addr_idx = addr[ADDR_W+OFFSET_W-1:OFFSET_W];

    // The access edge is the LATENCY-th edge after acceptance: the counter is
    // loaded with LATENCY-1 and the access happens on the edge that sees zero.
    assign access_fire = (state_q == BUSY) && (cnt_q == 8'd0);

    // NOTE: every register below uses non-blocking assignment so that all
    // state updates at an edge see the pre-edge values, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            req_we_q   <= 1'b0;
            req_idx_q  <= '0;
            req_data_q <= '0;
            data_o     <= '0;
            ack        <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs) begin
                        req_we_q   <= we;
                        req_idx_q  <= addr_idx;
                        req_data_q <= data_i;
                        cnt_q      <= 8'(LATENCY - 1);
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    // Request inputs are ignored here; only the latched copy counts.
                    if (cnt_q == 8'd0) begin
                        if (!req_we_q) begin
                            data_o <= mem_q[req_idx_q];
                        end
                        ack     <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset so that line
    // contents survive a reset; a reset at the access edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && access_fire && req_we_q) begin
            mem_q[req_idx_q] <= req_data_q;
        end
    end

    // An unknown request strobe outside reset means a broken controller.
    assert property (@(posedge clk) disable iff (rst) !$isunknown(cs));

endmodule : ext_line_memory

// File: tb/tb_ext_line_memory.sv
// -----------------------------------------------------------------------------
// tb_ext_line_memory
// Self-checking bench for ext_line_memory. Two instances share the clock,
// reset and request payload: one with LATENCY=10, one with LATENCY=1, each
// with its own cs. A line-array reference model per instance predicts read
// data and the expected data_o hold value; ack timing is predicted from the
// latency contract (ack high in the cycle after the LATENCY-th edge following
// the accepting edge).
// -----------------------------------------------------------------------------
module tb_ext_line_memory;
    import mem_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [LINE_W-1:0] line_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs10, cs1;
    logic        we;
    logic [31:0] addr;
    line_t       data_i;
    line_t       dout10, dout1;
    logic        ack10, ack1;

    always #5 clk = ~clk;

    ext_line_memory #(.LATENCY(10), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut10 (
        .clk(clk), .rst(rst), .cs(cs10), .we(we), .addr(addr),
        .data_i(data_i), .data_o(dout10), .ack(ack10)
    );

    ext_line_memory #(.LATENCY(1), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut1 (
        .clk(clk), .rst(rst), .cs(cs1), .we(we), .addr(addr),
        .data_i(data_i), .data_o(dout1), .ack(ack1)
    );

    // Reference model: line contents and the expected held data_o per instance.
    line_t mem10 [DEPTH];
    line_t mem1  [DEPTH];
    bit    valid10 [DEPTH];
    bit    valid1  [DEPTH];
    line_t exp_do10, exp_do1;

    int errors = 0;
    int checks = 0;

    function automatic line_t rand_line();
        line_t r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'(a[ADDR_W+OFFSET_W-1:OFFSET_W]);
    endfunction

    // One complete transaction on the selected instance. With scramble set,
    // the payload and cs are randomised while the request is in flight.
    task automatic transact(input bit sel1, input bit w, input logic [31:0] a,
                            input line_t d, input bit scramble, input string name);
        int    lat = sel1 ? 1 : 10;
        int    idx = line_of(a);
        int    n_acks = 0;
        int    ack_cycle = -1;
        line_t rd;
        line_t exp_rd;

        @(posedge clk); #1;
        we = w; addr = a; data_i = d;
        if (sel1) cs1 = 1'b1; else cs10 = 1'b1;
        @(posedge clk); #1;                       // accepting edge E0
        for (int k = 1; k <= lat + 3; k++) begin
            if (scramble && k <= lat) begin
                we     = 1'($urandom_range(0, 1));
                addr   = $urandom;
                data_i = rand_line();
                if (sel1) cs1 = 1'($urandom_range(0, 1));
                else      cs10 = 1'($urandom_range(0, 1));
            end else begin
                cs1 = 1'b0; cs10 = 1'b0;
            end
            @(posedge clk); #1;
            if ((sel1 ? ack1 : ack10) === 1'b1) begin
                n_acks++;
                ack_cycle = k;
            end
        end
        cs1 = 1'b0; cs10 = 1'b0;
        rd = sel1 ? dout1 : dout10;

        if (w) begin
            if (sel1) begin mem1[idx] = d;  valid1[idx] = 1'b1;  end
            else      begin mem10[idx] = d; valid10[idx] = 1'b1; end
        end else begin
            if (sel1) exp_do1 = mem1[idx]; else exp_do10 = mem10[idx];
        end
        exp_rd = sel1 ? exp_do1 : exp_do10;

        checks++;
        if (n_acks !== 1 || ack_cycle !== lat) begin
            errors++;
            $display("FAIL %s ack: pulses=%0d at cycle %0d, required 1 pulse at cycle %0d",
                     name, n_acks, ack_cycle, lat);
        end
        checks++;
        if (rd !== exp_rd) begin
            errors++;
            $display("FAIL %s data_o: got %h required %h", name, rd, exp_rd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cs10 = 1'b0; cs1 = 1'b0; we = 1'b0; addr = '0; data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        exp_do10 = '0; exp_do1 = '0;
        checks++;
        if (ack10 !== 1'b0 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: got %b/%b required 0/0", ack10, ack1);
        end
        checks++;
        if (dout10 !== '0 || dout1 !== '0) begin
            errors++;
            $display("FAIL reset_data_o: got %h / %h required 0", dout10, dout1);
        end
        rst = 1'b0;
    endtask

    // Preload line 3, reset (array must persist), then read it back.
    task automatic test_reset_then_read();
        transact(1'b0, 1'b1, 32'h0000_0060, {8{32'hA5A5_0003}}, 1'b0, "preload3");
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        exp_do10 = '0; exp_do1 = '0;
        transact(1'b0, 1'b0, 32'h0000_0060, '0, 1'b0, "read3_after_reset");
    endtask

    task automatic test_write_then_read();
        transact(1'b0, 1'b1, 32'h0000_0080, {8{32'hDEAD_BEEF}}, 1'b0, "write4");
        transact(1'b0, 1'b0, 32'h0000_0080, '0, 1'b0, "read4");
        transact(1'b0, 1'b0, 32'h0000_0060, '0, 1'b0, "read3_neighbour");
    endtask

    task automatic test_busy_ignore();
        transact(1'b0, 1'b1, 32'h0000_00E0, rand_line(), 1'b1, "busy_write7");
        transact(1'b0, 1'b0, 32'h0000_00E0, '0, 1'b1, "busy_read7");
    endtask

    // Abort a write to line 5 in its fourth BUSY cycle.
    task automatic test_reset_mid_write();
        int n_acks = 0;
        transact(1'b0, 1'b1, 32'h0000_00A0, rand_line(), 1'b0, "pre5");
        transact(1'b0, 1'b0, 32'h0000_00A0, '0, 1'b0, "pre5_read");
        @(posedge clk); #1;
        cs10 = 1'b1; we = 1'b1; addr = 32'h0000_00A0; data_i = {8{32'h1111_1111}};
        @(posedge clk); #1;                       // E0: BUSY cycle 1 begins
        cs10 = 1'b0;
        for (int k = 1; k <= 3; k++) begin        // BUSY cycles 2..4
            @(posedge clk); #1;
            if (ack10 === 1'b1) n_acks++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_do10 = '0; exp_do1 = '0;
        for (int k = 0; k < 15; k++) begin
            if (ack10 === 1'b1) n_acks++;
            @(posedge clk); #1;
        end
        checks++;
        if (n_acks !== 0) begin
            errors++;
            $display("FAIL abort_no_ack: pulses=%0d required 0", n_acks);
        end
        checks++;
        if (dout10 !== '0) begin
            errors++;
            $display("FAIL abort_data_o: got %h required 0", dout10);
        end
        transact(1'b0, 1'b0, 32'h0000_00A0, '0, 1'b0, "abort_line5_kept");
    endtask

    // LATENCY=1: single transactions, then back-to-back reads with cs held.
    task automatic test_back_to_back();
        int    n = 0;
        int    ack_k [2];
        line_t rdat  [2];
        transact(1'b1, 1'b1, 32'h0000_0000, rand_line(), 1'b0, "l1_write0");
        transact(1'b1, 1'b1, 32'h0000_0020, rand_line(), 1'b0, "l1_write1");
        transact(1'b1, 1'b0, 32'h0000_0000, '0, 1'b0, "l1_read0");
        ack_k[0] = -1; ack_k[1] = -1; rdat[0] = '0; rdat[1] = '0;
        @(posedge clk); #1;
        cs1 = 1'b1; we = 1'b0; addr = 32'h0000_0000;
        @(posedge clk); #1;                       // E0
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (ack1 === 1'b1) begin
                if (n < 2) begin ack_k[n] = k; rdat[n] = dout1; end
                n++;
                if (n == 1) addr = 32'h0000_0020;
                else        cs1 = 1'b0;
            end
        end
        cs1 = 1'b0;
        exp_do1 = mem1[1];
        // First ack after E1; ACK->IDLE at E2; IDLE accepts at E3; ack after E4.
        checks++;
        if (n !== 2 || ack_k[0] !== 1 || ack_k[1] !== 4) begin
            errors++;
            $display("FAIL b2b_ack: pulses=%0d at %0d,%0d required 2 at 1,4",
                     n, ack_k[0], ack_k[1]);
        end
        checks++;
        if (rdat[0] !== mem1[0] || rdat[1] !== mem1[1]) begin
            errors++;
            $display("FAIL b2b_data: got %h / %h required %h / %h",
                     rdat[0], rdat[1], mem1[0], mem1[1]);
        end
    endtask

    task automatic test_aliasing();
        transact(1'b0, 1'b1, 32'h0000_8020, rand_line(), 1'b0, "alias_write");
        transact(1'b0, 1'b0, 32'h0000_0020, '0, 1'b0, "alias_read");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            bit          sel1 = 1'($urandom_range(0, 1));
            int          idx  = 8 + $urandom_range(0, 7);
            logic [31:0] a    = {$urandom} & 32'hFFFF_801F;
            bit          valid;
            bit          w;
            a[ADDR_W+OFFSET_W-1:OFFSET_W] = ADDR_W'(idx);
            valid = sel1 ? valid1[idx] : valid10[idx];
            w = valid ? 1'($urandom_range(0, 1)) : 1'b1;
            transact(sel1, w, a, rand_line(), !sel1 && ($urandom_range(0, 1) == 1),
                     $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_reset_then_read();
        test_write_then_read();
        test_busy_ignore();
        test_reset_mid_write();
        test_back_to_back();
        test_aliasing();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound in case a wait never resolves.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule : tb_ext_line_memory
